regfile_sequencer: RTL and testbench

- Initiator-side driver for the 32 x 32-bit `RegisterFile` write and read-1 ports.
- Forwards single writes from the write-back stage to the register file.
- Runs a hardware clear sweep that writes 0 to all 32 registers.
- Optionally runs a dump sweep that streams every register out over a valid/ready port for debug.
- Sits between the WB stage / debug controller and the register file; owns `WriteReg`, `WriteData`, `RegWrite` and `ReadReg1`.

---
 rtl/regfile_sequencer_if.sv | 36 +++
 rtl/regfile_sequencer.sv | 141 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if
//   Bundles the three buses the sequencer sits on:
//     write-back request : wb_valid, wb_reg, wb_data -> wb_ready
//     register file      : WriteReg, WriteData, RegWrite, ReadReg1 -> ReadData1
//     debug dump stream  : dump_valid, dump_index, dump_data -> dump_ready
//   master : the sequencer's view (drives the register file and dump stream).
//   slave  : the surroundings (WB stage, register file, dump consumer).
interface regfile_sequencer_if;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_ready;

    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [31:0] ReadData1;

    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;

    modport master (
        input  wb_valid, wb_reg, wb_data, ReadData1, dump_ready,
        output wb_ready, WriteReg, WriteData, RegWrite, ReadReg1,
               dump_valid, dump_index, dump_data
    );

    modport slave (
        output wb_valid, wb_reg, wb_data, ReadData1, dump_ready,
        input  wb_ready, WriteReg, WriteData, RegWrite, ReadReg1,
               dump_valid, dump_index, dump_data
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
//   Initiator-side driver for a 32 x 32-bit register file. Forwards single
//   write-back writes, runs a clear sweep writing 0 to every register, and
//   (optionally) streams every register out over a valid/ready dump port.
//
//   Ports:
//     clk, rst_n  : clock (rising edge), asynchronous active-low reset
//     init_start  : start clear sweep (sampled in IDLE only)
//     dump_start  : start dump sweep (sampled in IDLE only)
//     bus         : regfile_sequencer_if.master (WB, register file, dump)
//     busy        : state is not IDLE
//     done        : one-cycle pulse when a sweep completes
//
//   Build option: define REGSEQ_DUMP_EN to compile in the dump sweep. Without
//   it dump_start is ignored and the dump outputs and ReadReg1 are tied 0.
module regfile_sequencer (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_start,
    input  logic                      dump_start,
    regfile_sequencer_if.master       bus,
    output logic                      busy,
    output logic                      done
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CLEAR    = 2'd1;
`ifdef REGSEQ_DUMP_EN
    localparam logic [1:0] DUMP_RD  = 2'd2;
    localparam logic [1:0] DUMP_OUT = 2'd3;
`endif

    logic [1:0]  state;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;

    assign busy         = (state != IDLE);
    assign bus.wb_ready = (state == IDLE);
    assign bus.WriteReg  = writeReg;
    assign bus.WriteData = writeData;
    assign bus.RegWrite  = regWrite;

`ifdef REGSEQ_DUMP_EN
    logic [4:0]  readReg1;
    logic        dumpValid;
    logic [4:0]  dumpIndex;
    logic [31:0] dumpData;

    assign bus.ReadReg1   = readReg1;
    assign bus.dump_valid = dumpValid;
    assign bus.dump_index = dumpIndex;
    assign bus.dump_data  = dumpData;
`else
    assign bus.ReadReg1   = 5'd0;
    assign bus.dump_valid = 1'b0;
    assign bus.dump_index = 5'd0;
    assign bus.dump_data  = 32'd0;

    // Dump-side inputs have no consumer in this build.
    logic unusedDumpIn;
    assign unusedDumpIn = ^{bus.ReadData1, bus.dump_ready, dump_start};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            writeReg  <= 5'd0;
            writeData <= 32'd0;
            regWrite  <= 1'b0;
            done      <= 1'b0;
`ifdef REGSEQ_DUMP_EN
            readReg1  <= 5'd0;
            dumpValid <= 1'b0;
            dumpIndex <= 5'd0;
            dumpData  <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // One action per edge; a lower-priority request seen
                    // alongside a higher one is simply not accepted.
                    regWrite <= 1'b0;
                    if (init_start) begin
                        state     <= CLEAR;
                        regWrite  <= 1'b1;
                        writeReg  <= 5'd0;
                        writeData <= 32'd0;
`ifdef REGSEQ_DUMP_EN
                    end else if (dump_start) begin
                        state    <= DUMP_RD;
                        readReg1 <= 5'd0;
`endif
                    end else if (bus.wb_valid) begin
                        regWrite  <= 1'b1;
                        writeReg  <= bus.wb_reg;
                        writeData <= bus.wb_data;
                    end
                end

                CLEAR: begin
                    // Register 31 is committed at this edge; stop here so
                    // the address never wraps back to 0.
                    if (writeReg == 5'd31) begin
                        regWrite <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        writeReg <= writeReg + 5'd1;
                    end
                end

`ifdef REGSEQ_DUMP_EN
                DUMP_RD: begin
                    // Read port is combinational: capture it one cycle after
                    // the address was registered.
                    dumpData  <= bus.ReadData1;
                    dumpIndex <= readReg1;
                    dumpValid <= 1'b1;
                    state     <= DUMP_OUT;
                end

                DUMP_OUT: begin
                    if (dumpValid && bus.dump_ready) begin
                        dumpValid <= 1'b0;
                        if (dumpIndex == 5'd31) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            readReg1 <= readReg1 + 5'd1;
                            state    <= DUMP_RD;
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic init_start;
    logic dump_start;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_sequencer_if bus();

    regfile_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .dump_start (dump_start),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    // Register file model: combinational read, write at the rising edge.
    logic [31:0] rf [32] = '{default: 32'hFFFF_FFFF};
    always @(posedge clk) if (bus.RegWrite === 1'b1) rf[bus.WriteReg] <= bus.WriteData;
    assign bus.ReadData1 = rf[bus.ReadReg1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkIdleZero(input string tag);
        chk({tag, "_RegWrite"}, 32'(bus.RegWrite), 32'd0);
        chk({tag, "_WriteReg"}, 32'(bus.WriteReg), 32'd0);
        chk({tag, "_WriteData"}, bus.WriteData, 32'd0);
        chk({tag, "_ReadReg1"}, 32'(bus.ReadReg1), 32'd0);
        chk({tag, "_dump_valid"}, 32'(bus.dump_valid), 32'd0);
        chk({tag, "_dump_index"}, 32'(bus.dump_index), 32'd0);
        chk({tag, "_dump_data"}, bus.dump_data, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_wb_ready"}, 32'(bus.wb_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] exp9;
        int doneSeen;

        rst_n = 1'b0;
        init_start = 1'b0;
        dump_start = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_reg = 5'd0;
        bus.wb_data = 32'd0;
        bus.dump_ready = 1'b0;
        tick();
        tick();
        chkIdleZero("reset");
        rst_n = 1'b1;
        tick();

        // Single write-back write.
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd1; bus.wb_data = 32'd37;
        tick();
        bus.wb_valid = 1'b0;
        chk("wb_RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("wb_WriteReg", 32'(bus.WriteReg), 32'd1);
        chk("wb_WriteData", bus.WriteData, 32'd37);
        tick();
        chk("wb_RegWrite_drop", 32'(bus.RegWrite), 32'd0);
        chk("wb_rf1", rf[1], 32'd37);

        // Back-to-back write-back writes.
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hA5;
        tick();
        chk("b2b0_WriteReg", 32'(bus.WriteReg), 32'd5);
        bus.wb_reg = 5'd6; bus.wb_data = 32'h66;
        tick();
        bus.wb_valid = 1'b0;
        chk("b2b1_RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("b2b1_WriteReg", 32'(bus.WriteReg), 32'd6);
        chk("b2b1_WriteData", bus.WriteData, 32'h66);
        tick();
        chk("b2b_rf5", rf[5], 32'hA5);
        chk("b2b_rf6", rf[6], 32'h66);

        // All three requests at once: clear wins, WB held throughout.
        init_start = 1'b1; dump_start = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 32'd99;
        tick();
        init_start = 1'b0; dump_start = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_wb_ready", 32'(bus.wb_ready), 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("clr_RegWrite_%0d", i), 32'(bus.RegWrite), 32'd1);
            chk($sformatf("clr_WriteReg_%0d", i), 32'(bus.WriteReg), 32'(i));
            chk($sformatf("clr_WriteData_%0d", i), bus.WriteData, 32'd0);
            chk($sformatf("clr_done_%0d", i), 32'(done), 32'd0);
            tick();
        end
        chk("clr_done", 32'(done), 32'd1);
        chk("clr_busy_end", 32'(busy), 32'd0);
        chk("clr_RegWrite_end", 32'(bus.RegWrite), 32'd0);
        chk("clr_rf1", rf[1], 32'd0);
        chk("clr_rf9", rf[9], 32'd0);
        chk("clr_rf31", rf[31], 32'd0);
        // WB still held: accepted now that the sequencer is idle again.
        tick();
        bus.wb_valid = 1'b0;
        chk("post_wb_RegWrite", 32'(bus.RegWrite), 32'd1);
        chk("post_wb_WriteReg", 32'(bus.WriteReg), 32'd9);
        chk("post_wb_WriteData", bus.WriteData, 32'd99);
        chk("post_wb_done", 32'(done), 32'd0);
        tick();
        chk("post_wb_rf9", rf[9], 32'd99);
        exp9 = 32'd99;

`ifdef REGSEQ_DUMP_EN
        // Preload register k with k*3, then dump with a stalling consumer.
        for (int k = 0; k < 32; k++) begin
            bus.wb_valid = 1'b1; bus.wb_reg = 5'(k); bus.wb_data = 32'(k * 3);
            tick();
        end
        bus.wb_valid = 1'b0;
        tick();
        exp9 = 32'd27;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("dump_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 32; k++) begin
            int w = 0;
            while (bus.dump_valid !== 1'b1 && w < 8) begin
                tick();
                w++;
            end
            chk($sformatf("dump_valid_%0d", k), 32'(bus.dump_valid), 32'd1);
            chk($sformatf("dump_index_%0d", k), 32'(bus.dump_index), 32'(k));
            chk($sformatf("dump_data_%0d", k), bus.dump_data, 32'(k * 3));
            bus.dump_ready = 1'b0;
            tick();
            chk($sformatf("dump_hold_valid_%0d", k), 32'(bus.dump_valid), 32'd1);
            chk($sformatf("dump_hold_index_%0d", k), 32'(bus.dump_index), 32'(k));
            chk($sformatf("dump_hold_data_%0d", k), bus.dump_data, 32'(k * 3));
            bus.dump_ready = 1'b1;
            tick();
            bus.dump_ready = 1'b0;
            chk($sformatf("dump_drop_%0d", k), 32'(bus.dump_valid), 32'd0);
            chk($sformatf("dump_done_%0d", k), 32'(done), (k == 31) ? 32'd1 : 32'd0);
        end
        chk("dump_busy_end", 32'(busy), 32'd0);
        tick();
`else
        // Dump disabled: the request must be ignored.
        dump_start = 1'b1;
        tick();
        chk("nodump_busy", 32'(busy), 32'd0);
        chk("nodump_valid", 32'(bus.dump_valid), 32'd0);
        tick();
        dump_start = 1'b0;
        chk("nodump_busy2", 32'(busy), 32'd0);
        chk("nodump_valid2", 32'(bus.dump_valid), 32'd0);
        chk("nodump_ReadReg1", 32'(bus.ReadReg1), 32'd0);
`endif

        // Reset in the middle of a clear sweep (cycle 10).
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("midclr_WriteReg", 32'(bus.WriteReg), 32'd9);
        rst_n = 1'b0;
        #1;
        chkIdleZero("midrst");
        tick();
        rst_n = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) doneSeen++;
            tick();
        end
        chk("midrst_no_done", 32'(doneSeen), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rf5", rf[5], 32'd0);
        chk("midrst_rf9", rf[9], exp9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
